// File: rtl/text_lcd_refresh_ctrl.sv
// Write sequencer for an HD44780-compatible 16x2 character LCD (8-bit bus, write-only).
// After the power-up wait and the four init commands, it redraws all 32 cells forever:
// set-DDRAM-address for line 1, 16 characters, set-address for line 2, 16 characters.
// Each character is preceded by a 2-cycle fetch so the upstream chain may register once.
module text_lcd_refresh_ctrl #(
    parameter int PWR_WAIT = 1000000,
    parameter int CMD_WAIT = 2000,
    parameter int CLR_WAIT = 100000,
    parameter int E_CYC    = 25,
    parameter int T_SU     = 2
) (
    input  logic       CLK,
    input  logic       RESETN,
    output logic [4:0] CHAR_ADDR,
    input  logic [7:0] CHAR_DATA,
    output logic       LCD_E,
    output logic       LCD_RS,
    output logic       LCD_RW,
    output logic [7:0] LCD_DATA,
    output logic       INIT_DONE,
    output logic       REFRESH_DONE
);

    localparam int MAX_A  = (PWR_WAIT > CLR_WAIT) ? PWR_WAIT : CLR_WAIT;
    localparam int MAX_B  = (CMD_WAIT > E_CYC) ? CMD_WAIT : E_CYC;
    localparam int MAX_N  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CNT_W  = $clog2(MAX_N + 1);

    localparam logic [CNT_W-1:0] PWR_END   = CNT_W'(PWR_WAIT - 1);
    localparam logic [CNT_W-1:0] CMD_END   = CNT_W'(CMD_WAIT - 1);
    localparam logic [CNT_W-1:0] CLR_END   = CNT_W'(CLR_WAIT - 1);
    localparam logic [CNT_W-1:0] E_END     = CNT_W'(E_CYC - 1);
    localparam logic [CNT_W-1:0] SU_END    = CNT_W'(T_SU - 1);
    localparam logic [CNT_W-1:0] FETCH_END = CNT_W'(1);

    typedef enum logic [2:0] {S_PWR, S_INIT, S_ADDR1, S_CHARS1, S_ADDR2, S_CHARS2} seq_t;
    typedef enum logic [1:0] {PH_FETCH, PH_SETUP, PH_EHI, PH_WAIT} phase_t;

    seq_t             seq_q, seq_d;
    phase_t           phase_q, phase_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       idx_q, idx_d;
    logic [3:0]       col_q, col_d;
    logic [4:0]       addr_q, addr_d;
    logic             e_q, e_d;
    logic             rs_q, rs_d;
    logic [7:0]       data_q, data_d;
    logic             init_done_q, init_done_d;
    logic             refresh_done_q, refresh_done_d;
    logic             start;
    logic [CNT_W-1:0] wait_end;

    // State register; reset aborts any transaction and drops every output at once.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            seq_q          <= S_PWR;
            phase_q        <= PH_SETUP;
            cnt_q          <= '0;
            idx_q          <= '0;
            col_q          <= '0;
            addr_q         <= '0;
            e_q            <= 1'b0;
            rs_q           <= 1'b0;
            data_q         <= 8'h00;
            init_done_q    <= 1'b0;
            refresh_done_q <= 1'b0;
        end else begin
            seq_q          <= seq_d;
            phase_q        <= phase_d;
            cnt_q          <= cnt_d;
            idx_q          <= idx_d;
            col_q          <= col_d;
            addr_q         <= addr_d;
            e_q            <= e_d;
            rs_q           <= rs_d;
            data_q         <= data_d;
            init_done_q    <= init_done_d;
            refresh_done_q <= refresh_done_d;
        end
    end

    // Sequence/phase stepping; a finished wait selects the next item and launches its transaction.
    always_comb begin
        seq_d          = seq_q;
        phase_d        = phase_q;
        cnt_d          = cnt_q;
        idx_d          = idx_q;
        col_d          = col_q;
        addr_d         = addr_q;
        e_d            = e_q;
        rs_d           = rs_q;
        data_d         = data_q;
        init_done_d    = init_done_q;
        refresh_done_d = 1'b0;
        start          = 1'b0;
        // Only the clear-display command needs the long wait.
        wait_end       = (seq_q == S_INIT && idx_q == 2'd3) ? CLR_END : CMD_END;

        if (seq_q == S_PWR) begin
            if (cnt_q == PWR_END) begin
                seq_d = S_INIT;
                idx_d = 2'd0;
                start = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else begin
            case (phase_q)
                PH_FETCH: begin
                    if (cnt_q == FETCH_END) begin
                        rs_d    = 1'b1;
                        data_d  = CHAR_DATA;
                        phase_d = PH_SETUP;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                PH_SETUP: begin
                    if (cnt_q == SU_END) begin
                        e_d     = 1'b1;
                        phase_d = PH_EHI;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                PH_EHI: begin
                    if (cnt_q == E_END) begin
                        e_d     = 1'b0;
                        phase_d = PH_WAIT;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    if (cnt_q == wait_end) begin
                        start = 1'b1;
                        case (seq_q)
                            S_INIT: begin
                                if (idx_q == 2'd3) begin
                                    init_done_d = 1'b1;
                                    seq_d       = S_ADDR1;
                                end else begin
                                    idx_d = idx_q + 1'b1;
                                end
                            end
                            S_ADDR1: begin
                                seq_d = S_CHARS1;
                                col_d = 4'd0;
                            end
                            S_CHARS1: begin
                                if (col_q == 4'd15) begin
                                    seq_d = S_ADDR2;
                                    col_d = 4'd0;
                                end else begin
                                    col_d = col_q + 1'b1;
                                end
                            end
                            S_ADDR2: begin
                                seq_d = S_CHARS2;
                                col_d = 4'd0;
                            end
                            S_CHARS2: begin
                                if (col_q == 4'd15) begin
                                    seq_d          = S_ADDR1;
                                    col_d          = 4'd0;
                                    refresh_done_d = 1'b1;
                                end else begin
                                    col_d = col_q + 1'b1;
                                end
                            end
                            default: ;
                        endcase
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            endcase
        end

        // Launch: characters first fetch from upstream, instructions go straight to setup.
        if (start) begin
            cnt_d = '0;
            if (seq_d == S_CHARS1 || seq_d == S_CHARS2) begin
                phase_d = PH_FETCH;
                addr_d  = {(seq_d == S_CHARS2), col_d};
            end else begin
                phase_d = PH_SETUP;
                rs_d    = 1'b0;
                case (seq_d)
                    S_INIT: begin
                        case (idx_d)
                            2'd0:    data_d = 8'h38;
                            2'd1:    data_d = 8'h0C;
                            2'd2:    data_d = 8'h06;
                            default: data_d = 8'h01;
                        endcase
                    end
                    S_ADDR2: data_d = 8'hC0;
                    default: data_d = 8'h80;
                endcase
            end
        end
    end

    assign CHAR_ADDR    = addr_q;
    assign LCD_E        = e_q;
    assign LCD_RS       = rs_q;
    assign LCD_RW       = 1'b0;
    assign LCD_DATA     = data_q;
    assign INIT_DONE    = init_done_q;
    assign REFRESH_DONE = refresh_done_q;

endmodule

// File: tb/tb_text_lcd_refresh_ctrl.sv
// Scoreboard bench for text_lcd_refresh_ctrl: expected LCD transactions are queued from a
// list-level model of the init/refresh sequence; a monitor pops one per E strobe and also
// checks E width, inter-strobe spacing, data stability and the status flags.
module tb_text_lcd_refresh_ctrl;

    localparam int PWR_W = 20;
    localparam int CMD_W = 4;
    localparam int CLR_W = 10;
    localparam int E_C   = 2;
    localparam int TSU   = 1;

    logic       clk;
    logic       rst_n;
    logic [4:0] char_addr;
    logic [7:0] char_data;
    logic       lcd_e, lcd_rs, lcd_rw, init_done, refresh_done;
    logic [7:0] lcd_data;

    text_lcd_refresh_ctrl #(
        .PWR_WAIT(PWR_W), .CMD_WAIT(CMD_W), .CLR_WAIT(CLR_W), .E_CYC(E_C), .T_SU(TSU)
    ) dut (
        .CLK(clk), .RESETN(rst_n), .CHAR_ADDR(char_addr), .CHAR_DATA(char_data),
        .LCD_E(lcd_e), .LCD_RS(lcd_rs), .LCD_RW(lcd_rw), .LCD_DATA(lcd_data),
        .INIT_DONE(init_done), .REFRESH_DONE(refresh_done)
    );

    typedef struct {
        logic       rs;
        logic [7:0] data;
        int         wait_c;
    } txn_t;

    txn_t       exp_q[$];
    int         n_tests = 0;
    int         n_fail  = 0;
    int         cyc     = 0;
    int         rel_cyc = 0;

    // Upstream character source
    logic [7:0] tbl[32];
    logic       mode_reg = 1'b0;
    logic       ovr_en   = 1'b0;
    int         pass_cnt = 0;
    logic [7:0] up_now;
    logic [7:0] data_reg = 8'h00;

    // Monitor state
    logic       prev_e, prev_rs, prev_rd, prev_id;
    logic [7:0] prev_data;
    logic       hold_rs, stable_ok, have_fall;
    logic [7:0] hold_data;
    logic       cur_rs;
    logic [7:0] cur_data;
    int         cur_wait, rise_cyc, last_fall, last_wait, txn_idx, last_done_txn, done_cnt;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        up_now = tbl[char_addr];
        if (ovr_en && pass_cnt >= 1 && char_addr == 5'h13) up_now = 8'h50;
        char_data = mode_reg ? data_reg : up_now;
    end
    always @(posedge clk) data_reg <= up_now;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] exp_char(input int p, input logic [4:0] a);
        if (ovr_en && p >= 1 && a == 5'h13) return 8'h50;
        return tbl[a];
    endfunction

    task automatic push_txn(input logic rs, input logic [7:0] d, input int w);
        txn_t t;
        t.rs = rs; t.data = d; t.wait_c = w;
        exp_q.push_back(t);
    endtask

    task automatic push_init();
        push_txn(1'b0, 8'h38, CMD_W);
        push_txn(1'b0, 8'h0C, CMD_W);
        push_txn(1'b0, 8'h06, CMD_W);
        push_txn(1'b0, 8'h01, CLR_W);
    endtask

    task automatic push_pass(input int p);
        for (int line = 0; line < 2; line++) begin
            push_txn(1'b0, (line == 0) ? 8'h80 : 8'hC0, CMD_W);
            for (int col = 0; col < 16; col++)
                push_txn(1'b1, exp_char(p, 5'(line * 16 + col)), CMD_W);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_e"}, lcd_e, 0);
        chk({tag, "_rs"}, lcd_rs, 0);
        chk({tag, "_rw"}, lcd_rw, 0);
        chk({tag, "_data"}, lcd_data, 0);
        chk({tag, "_addr"}, char_addr, 0);
        chk({tag, "_init_done"}, init_done, 0);
        chk({tag, "_refresh_done"}, refresh_done, 0);
    endtask

    task automatic wait_refreshes(input int n, input int budget);
        int k = 0;
        while (done_cnt < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        n_tests++;
        if (done_cnt < n) begin
            n_fail++;
            $display("FAIL refresh_timeout: got %0d refreshes, expected %0d", done_cnt, n);
        end
    endtask

    // Monitor: one expected transaction per E rising edge, plus timing and flag checks.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_e = 0; prev_rs = 0; prev_data = 0; prev_rd = 0; prev_id = 0;
            have_fall = 0; txn_idx = 0; last_done_txn = 0; done_cnt = 0; pass_cnt = 0;
            stable_ok = 1; cur_wait = 0;
        end else begin
            chk("rw_low", lcd_rw, 0);
            if (lcd_e && !prev_e) begin
                if (exp_q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL txn_extra: got rs=%0d data=%02h, expected no transaction", lcd_rs, lcd_data);
                    cur_rs = lcd_rs; cur_data = lcd_data; cur_wait = CMD_W;
                end else begin
                    txn_t t;
                    t = exp_q.pop_front();
                    cur_rs = t.rs; cur_data = t.data; cur_wait = t.wait_c;
                    chk("txn_rs", lcd_rs, cur_rs);
                    chk("txn_data", lcd_data, cur_data);
                end
                if (have_fall)
                    chk("strobe_gap", cyc - last_fall, last_wait + TSU + (cur_rs ? 2 : 0));
                else
                    chk("power_gap", cyc - rel_cyc, PWR_W + TSU);
                chk("setup_stable", {prev_rs, prev_data}, {lcd_rs, lcd_data});
                chk("init_done_at_txn", init_done, (txn_idx >= 4) ? 1 : 0);
                hold_rs = lcd_rs; hold_data = lcd_data; stable_ok = 1;
                rise_cyc = cyc;
                txn_idx++;
            end else if (lcd_e) begin
                if (lcd_rs !== hold_rs || lcd_data !== hold_data) stable_ok = 0;
            end
            if (!lcd_e && prev_e) begin
                chk("e_width", cyc - rise_cyc, E_C);
                chk("hold_stable", stable_ok, 1);
                last_fall = cyc; last_wait = cur_wait; have_fall = 1;
            end
            if (init_done && !prev_id) chk("init_done_rise", cyc - last_fall, CLR_W);
            if (!init_done && prev_id) chk("init_done_sticky", init_done, 1);
            if (refresh_done) begin
                chk("refresh_width", prev_rd, 0);
                chk("refresh_txns", txn_idx - last_done_txn, (done_cnt == 0) ? 38 : 34);
                chk("refresh_time", cyc - last_fall, CMD_W);
                last_done_txn = txn_idx;
                done_cnt++;
                pass_cnt++;
            end
            prev_e = lcd_e; prev_rs = lcd_rs; prev_data = lcd_data;
            prev_rd = refresh_done; prev_id = init_done;
        end
    end

    initial begin
        int k;
        rst_n = 1'b1;
        for (int i = 0; i < 32; i++) tbl[i] = 8'h30 + 8'((i % 16) % 10);
        ovr_en = 1'b1;
        mode_reg = 1'b0;
        #2 rst_n = 1'b0;
        #1 chk_reset_outputs("async_reset");
        push_init();
        for (int p = 0; p < 5; p++) push_pass(p);
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset_hold");
        #1 rst_n = 1'b1;
        rel_cyc = cyc;
        wait_refreshes(3, 4000);

        // Abort mid-strobe after a random delay, then rerun with a registered random upstream.
        repeat ($urandom_range(0, 150)) @(negedge clk);
        k = 0;
        while (lcd_e !== 1'b1 && k < 400) begin
            @(negedge clk);
            k++;
        end
        chk("e_high_before_reset", lcd_e, 1);
        #1 rst_n = 1'b0;
        #1 chk_reset_outputs("mid_txn_reset");
        exp_q.delete();
        for (int i = 0; i < 32; i++) tbl[i] = 8'($urandom_range(0, 255));
        ovr_en = 1'b0;
        mode_reg = 1'b1;
        push_init();
        for (int p = 0; p < 3; p++) push_pass(p);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        rel_cyc = cyc;
        wait_refreshes(2, 3000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

endmodule
